// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_countdown_timer
//  Brief    : Down-counting BCD mm:ss timer with preset load, pause/resume,
//             expiry DONE pulse and a TICK-timed ALARM level.
//  Revision : 1.0  initial release
// ============================================================================
module bcd_countdown_timer #(
    parameter int MIN_TENS_MAX = 5,
    parameter int ALARM_TICKS  = 8
) (
    input  logic       cp_i,
    input  logic       cr_i,
    input  logic       tick_i,
    input  logic       load_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [3:0] d_mt_i,
    input  logic [3:0] d_mu_i,
    input  logic [3:0] d_st_i,
    input  logic [3:0] d_su_i,
    output logic [3:0] q_mt_o,
    output logic [3:0] q_mu_o,
    output logic [3:0] q_st_o,
    output logic [3:0] q_su_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       alarm_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] c_MT_MAX     = 4'(MIN_TENS_MAX);
    localparam logic [3:0] c_ALARM_LAST = 4'(ALARM_TICKS - 1);

    state_t     state_q;
    logic [3:0] mt_q, mu_q, st_q, su_q;
    logic [3:0] mt_d, mu_d, st_d, su_d;
    logic [3:0] alarm_cnt_q;
    logic       busy_q, done_q, alarm_q, err_q;

    logic       w_load_ok;
    logic       w_nonzero;
    logic       w_at_one;

    assign w_load_ok = (d_mt_i <= c_MT_MAX) && (d_mt_i <= 4'd9) && (d_mu_i <= 4'd9)
                    && (d_st_i <= 4'd5) && (d_su_i <= 4'd9);
    assign w_nonzero = |{mt_q, mu_q, st_q, su_q};
    assign w_at_one  = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd1);

    // One-second borrow chain: SU wraps to 9, ST to 5, MU to 9, MT just decrements.
    always_comb begin
        su_d = su_q - 4'd1;
        st_d = st_q;
        mu_d = mu_q;
        mt_d = mt_q;
        if (su_q == 4'd0) begin
            su_d = 4'd9;
            if (st_q == 4'd0) begin
                st_d = 4'd5;
                if (mu_q == 4'd0) begin
                    mu_d = 4'd9;
                    mt_d = mt_q - 4'd1;
                end else begin
                    mu_d = mu_q - 4'd1;
                end
            end else begin
                st_d = st_q - 4'd1;
            end
        end
    end

    always_ff @(posedge cp_i) begin
        if (cr_i) begin
            state_q     <= ST_IDLE;
            mt_q        <= 4'd0;
            mu_q        <= 4'd0;
            st_q        <= 4'd0;
            su_q        <= 4'd0;
            alarm_cnt_q <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // Only the highest-priority asserted control acts; lower ones (incl. TICK) are dropped.
            if (load_i) begin
                if (w_load_ok) begin
                    mt_q        <= d_mt_i;
                    mu_q        <= d_mu_i;
                    st_q        <= d_st_i;
                    su_q        <= d_su_i;
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    alarm_q     <= 1'b0;
                    alarm_cnt_q <= 4'd0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (stop_i) begin
                if (state_q == ST_RUN) begin
                    state_q <= ST_PAUSE;
                    busy_q  <= 1'b0;
                end
            end else if (start_i) begin
                if ((state_q == ST_IDLE || state_q == ST_PAUSE) && w_nonzero) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b1;
                end
            end else if (tick_i) begin
                case (state_q)
                    ST_RUN: begin
                        mt_q <= mt_d;
                        mu_q <= mu_d;
                        st_q <= st_d;
                        su_q <= su_d;
                        if (w_at_one) begin
                            state_q     <= ST_EXPIRED;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            alarm_q     <= 1'b1;
                            alarm_cnt_q <= 4'd0;
                        end
                    end
                    ST_EXPIRED: begin
                        if (alarm_cnt_q == c_ALARM_LAST) begin
                            alarm_cnt_q <= 4'd0;
                            alarm_q     <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            alarm_cnt_q <= alarm_cnt_q + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign q_mt_o  = mt_q;
    assign q_mu_o  = mu_q;
    assign q_st_o  = st_q;
    assign q_su_o  = su_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign alarm_o = alarm_q;
    assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_countdown_timer
//  Brief    : Directed + randomized bench against a seconds-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bcd_countdown_timer;

    localparam int MIN_TENS_MAX = 5;
    localparam int ALARM_TICKS  = 8;

    logic       cp_i = 1'b0;
    logic       cr_i, tick_i, load_i, start_i, stop_i;
    logic [3:0] d_mt_i, d_mu_i, d_st_i, d_su_i;
    logic [3:0] q_mt_o, q_mu_o, q_st_o, q_su_o;
    logic       busy_o, done_o, alarm_o, err_o;

    bcd_countdown_timer #(
        .MIN_TENS_MAX (MIN_TENS_MAX),
        .ALARM_TICKS  (ALARM_TICKS)
    ) u_dut (
        .cp_i    (cp_i),
        .cr_i    (cr_i),
        .tick_i  (tick_i),
        .load_i  (load_i),
        .start_i (start_i),
        .stop_i  (stop_i),
        .d_mt_i  (d_mt_i),
        .d_mu_i  (d_mu_i),
        .d_st_i  (d_st_i),
        .d_su_i  (d_su_i),
        .q_mt_o  (q_mt_o),
        .q_mu_o  (q_mu_o),
        .q_st_o  (q_st_o),
        .q_su_o  (q_su_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .alarm_o (alarm_o),
        .err_o   (err_o)
    );

    always #5 cp_i = ~cp_i;

    // Reference model: remaining time held as plain seconds.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int m_secs, m_state, m_alarm_left;
    bit m_done, m_alarm, m_err;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] secs_to_bcd(input int s);
        int m;
        m = s / 60;
        return {4'(m / 10), 4'(m % 10), 4'((s % 60) / 10), 4'(s % 10)};
    endfunction

    task automatic model_step(input bit cr, input bit ld, input bit sp, input bit st,
                              input bit tk, input int a, input int b, input int c, input int d);
        if (cr) begin
            m_secs = 0; m_state = M_IDLE; m_alarm_left = 0;
            m_done = 0; m_alarm = 0; m_err = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (ld) begin
            if (a <= MIN_TENS_MAX && a <= 9 && b <= 9 && c <= 5 && d <= 9) begin
                m_secs  = (a * 10 + b) * 60 + c * 10 + d;
                m_state = M_IDLE;
                m_alarm = 0;
            end else begin
                m_err = 1;
            end
        end else if (sp) begin
            if (m_state == M_RUN) m_state = M_PAUSE;
        end else if (st) begin
            if ((m_state == M_IDLE || m_state == M_PAUSE) && m_secs != 0) m_state = M_RUN;
        end else if (tk) begin
            if (m_state == M_RUN) begin
                m_secs--;
                if (m_secs == 0) begin
                    m_state = M_EXP; m_done = 1; m_alarm = 1; m_alarm_left = ALARM_TICKS;
                end
            end else if (m_state == M_EXP) begin
                m_alarm_left--;
                if (m_alarm_left == 0) begin
                    m_alarm = 0; m_state = M_IDLE;
                end
            end
        end
    endtask

    // Drive one cycle's inputs (called just after a falling edge), then check after the rising edge.
    task automatic cyc(input bit cr, input bit ld, input bit sp, input bit st, input bit tk,
                       input int a = 0, input int b = 0, input int c = 0, input int d = 0);
        cr_i = cr; load_i = ld; stop_i = sp; start_i = st; tick_i = tk;
        d_mt_i = 4'(a); d_mu_i = 4'(b); d_st_i = 4'(c); d_su_i = 4'(d);
        @(posedge cp_i);
        model_step(cr, ld, sp, st, tk, a, b, c, d);
        #1;
        check("q",     32'({q_mt_o, q_mu_o, q_st_o, q_su_o}), 32'(secs_to_bcd(m_secs)));
        check("busy",  32'(busy_o),  32'(m_state == M_RUN));
        check("done",  32'(done_o),  32'(m_done));
        check("alarm", 32'(alarm_o), 32'(m_alarm));
        check("err",   32'(err_o),   32'(m_err));
        @(negedge cp_i);
    endtask

    task automatic ld(input int a, input int b, input int c, input int d);
        cyc(0, 1, 0, 0, 0, a, b, c, d);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        m_secs = 0; m_state = M_IDLE; m_alarm_left = 0;
        m_done = 0; m_alarm = 0; m_err = 0;
        cr_i = 1; load_i = 0; stop_i = 0; start_i = 0; tick_i = 0;
        d_mt_i = 0; d_mu_i = 0; d_st_i = 0; d_su_i = 0;
        @(negedge cp_i);

        // Reset, then START at 00:00 has no effect
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        ticks(2);

        // 01:00 countdown to expiry, then full alarm window
        ld(0, 1, 0, 0);
        cyc(0, 0, 0, 1, 0);
        ticks(60);
        ticks(ALARM_TICKS + 2);

        // Full borrow chain, max legal preset, rejected presets
        ld(1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        ticks(1);
        ld(5, 9, 5, 9);
        ld(0, 0, 6, 0);
        ld(6, 0, 0, 0);
        ld(0, 10, 0, 0);
        ld(0, 0, 0, 15);

        // Pause/resume with same-edge TICK drops
        ld(0, 0, 0, 5);
        cyc(0, 0, 0, 1, 0);
        ticks(2);
        cyc(0, 0, 1, 0, 1);
        ticks(3);
        cyc(0, 0, 0, 1, 1);
        ticks(3);
        ticks(3);

        // Alarm cancelled by LOAD, START ignored while EXPIRED
        ld(0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        ticks(1);
        cyc(0, 0, 0, 1, 0);
        ticks(3);
        ld(0, 0, 3, 0);
        ticks(2);

        // Reset mid-run at 00:07
        ld(0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        ticks(3);
        cyc(1, 0, 0, 0, 0);
        ticks(5);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r_cr, r_ld, r_sp, r_st, r_tk;
            int a, b, c, d;
            r_cr = ($urandom_range(0, 299) == 0);
            r_ld = ($urandom_range(0, 39) == 0);
            r_sp = ($urandom_range(0, 29) == 0);
            r_st = ($urandom_range(0, 7) == 0);
            r_tk = ($urandom_range(0, 1) == 0);
            case ($urandom_range(0, 3))
                0: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15);
                         c = $urandom_range(0, 15); d = $urandom_range(0, 15); end
                1: begin a = 0; b = $urandom_range(0, 1);
                         c = $urandom_range(0, 5); d = $urandom_range(0, 9); end
                default: begin a = 0; b = 0;
                         c = $urandom_range(0, 1); d = $urandom_range(0, 9); end
            endcase
            cyc(r_cr, r_ld, r_sp, r_st, r_tk, a, b, c, d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
